// File: rtl/program_counter16_pkg.sv
// Shared constants for the cascaded 74LS161-style program counter.
package program_counter16_pkg;

    // One counter slice per nibble of the count.
    localparam int NIBBLE = 4;

    // Terminal count of a single slice; its ripple carry fires at this value.
    localparam logic [NIBBLE-1:0] NIBBLE_ALL_ONES = 4'hF;

    // Default counter width and the value the count returns to on reset.
    localparam int                  DEFAULT_WIDTH       = 16;
    localparam logic [DEFAULT_WIDTH-1:0] DEFAULT_RESET_VALUE = '0;

endpackage

// File: rtl/program_counter16_if.sv
// Control and data bus of the program counter.
// There is no valid/ready handshake here: load and count_en are plain level
// enables sampled on every falling edge of clock, and out/carry_out are
// always-valid state and combinational carry driven back by the counter.
interface program_counter16_if
    import program_counter16_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             load;
    logic             count_en;
    logic [WIDTH-1:0] in;
    logic [WIDTH-1:0] out;
    logic             carry_out;

    // Sequencer side: issues jumps and increments, observes the count.
    modport master (
        output load,
        output count_en,
        output in,
        input  out,
        input  carry_out
    );

    // Counter side.
    modport slave (
        input  load,
        input  count_en,
        input  in,
        output out,
        output carry_out
    );
endinterface

// File: rtl/program_counter16_counter4_161.sv
// One 4-bit synchronous counter slice with 74LS161 semantics:
// synchronous clear, parallel load, counting only when both ENP and ENT are
// high, and ripple carry out = terminal count gated by ENT.
module counter4_161
    import program_counter16_pkg::*;
#(
    parameter logic [NIBBLE-1:0] RESET_NIBBLE = '0
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic              load,
    input  logic              enp,
    input  logic              ent,
    input  logic [NIBBLE-1:0] in,
    output logic [NIBBLE-1:0] out,
    output logic              rco
);

    // Falling-edge state update: clear beats load, load beats count.
    always_ff @(negedge clock) begin
        if (!rst_n) begin
            out <= RESET_NIBBLE;
        end else if (load) begin
            out <= in;
        end else if (enp && ent) begin
            out <= out + 4'd1;
        end
    end

    // Carry is not gated by load, matching the original part.
    assign rco = (out == NIBBLE_ALL_ONES) & ent;

endmodule

// File: rtl/program_counter16.sv
// Program counter built from WIDTH/4 chained counter4_161 slices.
// Each slice's ENT is the previous slice's RCO, so a nibble only advances
// when every lower nibble is at 0xF and count_en is high.
module program_counter16
    import program_counter16_pkg::*;
#(
    parameter int               WIDTH       = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = DEFAULT_RESET_VALUE
) (
    input  logic                 clock,
    input  logic                 rst_n,
    program_counter16_if.slave   bus
);

    localparam int SLICES = WIDTH / NIBBLE;

    logic [WIDTH-1:0] count;
    logic [SLICES:0]  carry_chain;

    // Slice 0 is enabled directly by count_en.
    assign carry_chain[0] = bus.count_en;

    for (genvar k = 0; k < SLICES; k++) begin : g_slice
        counter4_161 #(
            .RESET_NIBBLE (RESET_VALUE[k*NIBBLE +: NIBBLE])
        ) u_slice (
            .clock (clock),
            .rst_n (rst_n),
            .load  (bus.load),
            .enp   (bus.count_en),
            .ent   (carry_chain[k]),
            .in    (bus.in[k*NIBBLE +: NIBBLE]),
            .out   (count[k*NIBBLE +: NIBBLE]),
            .rco   (carry_chain[k+1])
        );
    end

    assign bus.out       = count;
    assign bus.carry_out = carry_chain[SLICES];

endmodule

// File: tb/tb_program_counter16.sv
// Directed bench for program_counter16: a vector table covering reset,
// nibble carries, wrap, carry_out gating and load priority, plus a
// hand-written count/hold sequence.
module tb_program_counter16;
    import program_counter16_pkg::*;

    localparam int W = 16;

    logic clock;
    logic rst_n;

    program_counter16_if #(.WIDTH(W)) bus ();

    program_counter16 #(
        .WIDTH       (W),
        .RESET_VALUE (16'h0000)
    ) dut (
        .clock (clock),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Clock / reset
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        string          name;
        logic           rst_n;
        logic           load;
        logic           count_en;
        logic [W-1:0]   in;
        logic           chk_carry;
        logic           exp_carry;
        logic [W-1:0]   exp_out;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic add(input string name, input logic r, input logic l, input logic c,
                       input logic [W-1:0] d, input logic chk, input logic ec,
                       input logic [W-1:0] eo);
        vec_t v;
        v.name = name; v.rst_n = r; v.load = l; v.count_en = c; v.in = d;
        v.chk_carry = chk; v.exp_carry = ec; v.exp_out = eo;
        vecs.push_back(v);
    endtask

    // Driver: inputs change mid-cycle, carry checked before the falling
    // edge, count checked just after it.
    task automatic apply(input string name, input logic r, input logic l, input logic c,
                         input logic [W-1:0] d, input logic chk, input logic ec,
                         input logic [W-1:0] eo);
        rst_n        = r;
        bus.load     = l;
        bus.count_en = c;
        bus.in       = d;
        #1;
        if (chk) check({name, "_carry"}, {15'd0, bus.carry_out}, {15'd0, ec});
        @(negedge clock);
        #1;
        check({name, "_out"}, bus.out, eo);
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.load     = 1'b1;
        bus.count_en = 1'b1;
        bus.in       = 16'h1234;

        // Reset with load and count_en both asserted.
        add("rst0", 0, 1, 1, 16'h1234, 0, 0, 16'h0000);
        add("rst1", 0, 1, 1, 16'h1234, 1, 0, 16'h0000);

        foreach (vecs[i])
            apply(vecs[i].name, vecs[i].rst_n, vecs[i].load, vecs[i].count_en,
                  vecs[i].in, vecs[i].chk_carry, vecs[i].exp_carry, vecs[i].exp_out);
        vecs.delete();

        // Count 20 edges after reset release, then hold 3 edges.
        for (int i = 0; i < 20; i++)
            apply("count", 1, 0, 1, 16'hDEAD, 1, 0, W'(i + 1));
        for (int i = 0; i < 3; i++)
            apply("hold", 1, 0, 0, 16'hBEEF, 1, 0, 16'h0014);

        // Nibble carry chain.
        add("ld_00ff",  1, 1, 0, 16'h00FF, 1, 0, 16'h00FF);
        add("inc_00ff", 1, 0, 1, 16'h0000, 1, 0, 16'h0100);
        add("ld_0fff",  1, 1, 0, 16'h0FFF, 1, 0, 16'h0FFF);
        add("inc_0fff", 1, 0, 1, 16'h0000, 1, 0, 16'h1000);
        add("ld_000f",  1, 1, 0, 16'h000F, 1, 0, 16'h000F);
        add("inc_000f", 1, 0, 1, 16'h0000, 1, 0, 16'h0010);
        // Wrap and carry_out.
        add("ld_ffff",  1, 1, 0, 16'hFFFF, 1, 0, 16'hFFFF);
        add("wrap",     1, 0, 1, 16'h0000, 1, 1, 16'h0000);
        add("post_wrap",1, 0, 1, 16'h0000, 1, 0, 16'h0001);
        add("ld_ffff2", 1, 1, 0, 16'hFFFF, 1, 0, 16'hFFFF);
        add("hold_ffff",1, 0, 0, 16'h0000, 1, 0, 16'hFFFF);
        // Load does not gate carry_out; load wins over count.
        add("ld_at_ffff",1, 1, 1, 16'h1234, 1, 1, 16'h1234);
        // Load priority.
        add("ld_0010",  1, 1, 0, 16'h0010, 1, 0, 16'h0010);
        add("ld_abcd",  1, 1, 1, 16'hABCD, 1, 0, 16'hABCD);
        add("inc_abcd", 1, 0, 1, 16'h0000, 1, 0, 16'hABCE);
        // Reset mid-count.
        add("ld_0042",  1, 1, 0, 16'h0042, 1, 0, 16'h0042);
        add("inc_0042", 1, 0, 1, 16'h0000, 1, 0, 16'h0043);
        add("rst_mid",  0, 1, 1, 16'h5555, 1, 0, 16'h0000);
        add("after_rst",1, 0, 1, 16'h5555, 1, 0, 16'h0001);

        foreach (vecs[i])
            apply(vecs[i].name, vecs[i].rst_n, vecs[i].load, vecs[i].count_en,
                  vecs[i].in, vecs[i].chk_carry, vecs[i].exp_carry, vecs[i].exp_out);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
